// File: rtl/freq_display.sv
// ============================================================================
// Module      : freq_display
// Description : 16-bit binary to BCD (double-dabble) with 4-digit multiplexed
//               7-segment scanner, overflow dashes and leading-zero blanking.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module freq_display #(
    parameter int REFRESH_DIV   = 100000,
    parameter bit BLANK_LEADING = 1'b1
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic [15:0] FREQ,
    output logic [15:0] BCD,
    output logic        OVF,
    output logic        BUSY,
    output logic [3:0]  AN,
    output logic [6:0]  SEG,
    output logic        DP
);

    localparam int c_cnt_w = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [c_cnt_w-1:0] c_div_last = c_cnt_w'(REFRESH_DIV - 1);
    localparam logic [6:0] c_seg_blank = 7'b1111111;
    localparam logic [6:0] c_seg_dash  = 7'b0111111;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_state_next;
    logic [15:0]   r_last_freq;
    logic [15:0]   r_shreg;
    logic [19:0]   r_acc;
    logic [19:0]   w_adj;
    logic [3:0]    r_shift_cnt;
    logic [15:0]   r_bcd;
    logic          r_ovf;
    logic          r_busy;
    logic          w_start;

    logic [c_cnt_w-1:0] r_refresh;
    logic [1:0]         r_digit;
    logic [3:0]         r_an;
    logic [6:0]         r_seg;
    logic [3:0]         w_nib;
    logic               w_blank;
    logic [6:0]         w_seg;
    logic [3:0]         w_an;

    function automatic logic [6:0] f_seg(input logic [3:0] d);
        case (d)
            4'd0:    f_seg = 7'b1000000;
            4'd1:    f_seg = 7'b1111001;
            4'd2:    f_seg = 7'b0100100;
            4'd3:    f_seg = 7'b0110000;
            4'd4:    f_seg = 7'b0011001;
            4'd5:    f_seg = 7'b0010010;
            4'd6:    f_seg = 7'b0000010;
            4'd7:    f_seg = 7'b1111000;
            4'd8:    f_seg = 7'b0000000;
            4'd9:    f_seg = 7'b0010000;
            default: f_seg = c_seg_blank;
        endcase
    endfunction

    assign w_start = (r_state == S_IDLE) && (FREQ != r_last_freq);

    // Double-dabble correction: any nibble >= 5 would carry wrongly after the shift
    always_comb begin
        w_adj = r_acc;
        for (int i = 0; i < 5; i++) begin
            if (r_acc[4*i +: 4] >= 4'd5) begin
                w_adj[4*i +: 4] = r_acc[4*i +: 4] + 4'd3;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (w_start) w_state_next = S_SHIFT;
            S_SHIFT: if (r_shift_cnt == 4'd15) w_state_next = S_DONE;
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_last_freq <= 16'd0;
            r_shreg     <= 16'd0;
            r_acc       <= 20'd0;
            r_shift_cnt <= 4'd0;
            r_bcd       <= 16'd0;
            r_ovf       <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_shreg     <= FREQ;
                        r_last_freq <= FREQ;
                        r_acc       <= 20'd0;
                        r_shift_cnt <= 4'd0;
                        r_busy      <= 1'b1;
                    end
                end
                S_SHIFT: begin
                    {r_acc, r_shreg} <= {w_adj[18:0], r_shreg, 1'b0};
                    r_shift_cnt      <= r_shift_cnt + 4'd1;
                end
                S_DONE: begin
                    r_bcd  <= r_acc[15:0];
                    r_ovf  <= (r_acc[19:16] != 4'd0);
                    r_busy <= 1'b0;
                end
                default: begin
                    r_busy <= 1'b0;
                end
            endcase
        end
    end

    // Scanner: free-running, always shows the last completed conversion
    always_comb begin
        w_nib   = 4'd0;
        w_blank = 1'b0;
        case (r_digit)
            2'd0: begin
                w_nib   = r_bcd[3:0];
                w_blank = 1'b0;
            end
            2'd1: begin
                w_nib   = r_bcd[7:4];
                w_blank = (r_bcd[15:4] == 12'd0);
            end
            2'd2: begin
                w_nib   = r_bcd[11:8];
                w_blank = (r_bcd[15:8] == 8'd0);
            end
            default: begin
                w_nib   = r_bcd[15:12];
                w_blank = (r_bcd[15:12] == 4'd0);
            end
        endcase
        if (r_ovf) begin
            w_seg = c_seg_dash;
        end else if (BLANK_LEADING && w_blank) begin
            w_seg = c_seg_blank;
        end else begin
            w_seg = f_seg(w_nib);
        end
        w_an = ~(4'b0001 << r_digit);
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_refresh <= '0;
            r_digit   <= 2'd0;
            r_an      <= 4'b1111;
            r_seg     <= c_seg_blank;
        end else begin
            if (r_refresh == c_div_last) begin
                r_refresh <= '0;
                r_digit   <= r_digit + 2'd1;
            end else begin
                r_refresh <= r_refresh + 1'b1;
            end
            r_an  <= w_an;
            r_seg <= w_seg;
        end
    end

    assign BCD  = r_bcd;
    assign OVF  = r_ovf;
    assign BUSY = r_busy;
    assign AN   = r_an;
    assign SEG  = r_seg;
    assign DP   = 1'b1;

endmodule

`default_nettype wire

// File: tb/tb_freq_display.sv
// ============================================================================
// Module      : tb_freq_display
// Description : Directed + random checks of freq_display against an
//               arithmetic reference (decimal digits, scan position).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_freq_display;

    localparam int DIV = 4;

    logic        clk;
    logic        rst_n;
    logic [15:0] freq;

    logic [15:0] bcd_b, bcd_n;
    logic        ovf_b, ovf_n, busy_b, busy_n, dp_b, dp_n;
    logic [3:0]  an_b, an_n;
    logic [6:0]  seg_b, seg_n;

    int n_pass;
    int n_total;
    int scan_k;
    int exp_val;

    logic [6:0] segtab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                7'b0000000, 7'b0010000};
    int pow10 [4] = '{1, 10, 100, 1000};

    freq_display #(.REFRESH_DIV(DIV), .BLANK_LEADING(1'b1)) u_dut_blank (
        .CLK(clk), .RST_N(rst_n), .FREQ(freq), .BCD(bcd_b), .OVF(ovf_b),
        .BUSY(busy_b), .AN(an_b), .SEG(seg_b), .DP(dp_b)
    );

    freq_display #(.REFRESH_DIV(DIV), .BLANK_LEADING(1'b0)) u_dut_full (
        .CLK(clk), .RST_N(rst_n), .FREQ(freq), .BCD(bcd_n), .OVF(ovf_n),
        .BUSY(busy_n), .AN(an_n), .SEG(seg_n), .DP(dp_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        if (rst_n) scan_k++;
        else scan_k = 0;
        #1;
    endtask

    task automatic chk(input string tag, input logic [19:0] obs, input logic [19:0] want);
        n_total++;
        assert (obs === want) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, want);
    endtask

    function automatic logic [15:0] bcd_of(input int v);
        int m;
        m = v % 10000;
        return {4'(m / 1000), 4'((m / 100) % 10), 4'((m / 10) % 10), 4'(m % 10)};
    endfunction

    function automatic logic [6:0] seg_exp(input int dg, input bit blank);
        int m;
        if (exp_val > 9999) return 7'b0111111;
        m = exp_val % 10000;
        if (blank && dg >= 1 && m < pow10[dg]) return 7'b1111111;
        return segtab[(m / pow10[dg]) % 10];
    endfunction

    task automatic check_scan();
        int dg;
        logic [3:0] want_an;
        if (scan_k == 0) begin
            chk("an_idle", {16'd0, an_b}, 20'hF);
            chk("seg_idle", {13'd0, seg_b}, 20'h7F);
        end else begin
            dg = ((scan_k - 1) / DIV) % 4;
            want_an = 4'b1111 ^ (4'b0001 << dg);
            chk("an_blank", {16'd0, an_b}, {16'd0, want_an});
            chk("seg_blank", {13'd0, seg_b}, {13'd0, seg_exp(dg, 1'b1)});
            chk("an_full", {16'd0, an_n}, {16'd0, want_an});
            chk("seg_full", {13'd0, seg_n}, {13'd0, seg_exp(dg, 1'b0)});
        end
        chk("busy_idle", {19'd0, busy_b}, 20'd0);
    endtask

    task automatic scan_frame();
        chk("dp", {18'd0, dp_b, dp_n}, 20'h3);
        repeat (4 * DIV) begin
            tick();
            check_scan();
        end
    endtask

    task automatic convert(input int v);
        freq = 16'(v);
        tick();
        chk("busy_rise", {19'd0, busy_b}, 20'd1);
        repeat (16) tick();
        chk("busy_hold", {19'd0, busy_b}, 20'd1);
        chk("bcd_hold", {4'd0, bcd_b}, {4'd0, bcd_of(exp_val)});
        tick();
        chk("busy_fall", {19'd0, busy_b}, 20'd0);
        chk("bcd", {4'd0, bcd_b}, {4'd0, bcd_of(v)});
        chk("ovf", {19'd0, ovf_b}, {19'd0, v > 9999});
        chk("bcd_full", {4'd0, bcd_n}, {4'd0, bcd_of(v)});
        exp_val = v;
        tick();
    endtask

    initial begin
        int v;
        n_pass  = 0;
        n_total = 0;
        scan_k  = 0;
        exp_val = 0;
        rst_n   = 1'b0;
        freq    = 16'd0;
        tick();
        tick();
        chk("rst_an", {16'd0, an_b}, 20'hF);
        chk("rst_seg", {13'd0, seg_b}, 20'h7F);
        chk("rst_bcd", {4'd0, bcd_b}, 20'd0);
        chk("rst_ovf", {19'd0, ovf_b}, 20'd0);
        chk("rst_busy", {19'd0, busy_b}, 20'd0);

        rst_n = 1'b1;
        scan_frame();
        scan_frame();

        convert(1234);
        scan_frame();
        convert(9999);
        scan_frame();
        convert(10000);
        scan_frame();
        convert(65535);
        chk("bcd_65535", {4'd0, bcd_b}, 20'h05535);
        convert(7);
        scan_frame();

        // Input change mid-conversion is deferred to the next IDLE cycle
        freq = 16'd100;
        tick();
        repeat (4) tick();
        freq = 16'd250;
        repeat (13) tick();
        chk("skip_bcd100", {4'd0, bcd_b}, 20'h00100);
        chk("skip_busy0", {19'd0, busy_b}, 20'd0);
        tick();
        chk("skip_busy1", {19'd0, busy_b}, 20'd1);
        repeat (16) tick();
        chk("skip_hold", {4'd0, bcd_b}, 20'h00100);
        tick();
        chk("skip_bcd250", {4'd0, bcd_b}, 20'h00250);
        chk("skip_busyend", {19'd0, busy_b}, 20'd0);
        exp_val = 250;
        tick();
        scan_frame();

        // Reset in the middle of a conversion
        freq = 16'd4321;
        tick();
        repeat (7) tick();
        rst_n = 1'b0;
        tick();
        chk("abort_bcd", {4'd0, bcd_b}, 20'd0);
        chk("abort_busy", {19'd0, busy_b}, 20'd0);
        chk("abort_an", {16'd0, an_b}, 20'hF);
        chk("abort_seg", {13'd0, seg_b}, 20'h7F);
        exp_val = 0;
        rst_n = 1'b1;
        tick();
        chk("restart_busy", {19'd0, busy_b}, 20'd1);
        repeat (16) tick();
        chk("restart_hold", {4'd0, bcd_b}, 20'd0);
        tick();
        chk("restart_bcd", {4'd0, bcd_b}, 20'h04321);
        exp_val = 4321;
        tick();
        scan_frame();

        for (int i = 0; i < 10; i++) begin
            v = (i % 2 == 0) ? int'($urandom_range(0, 9999)) : int'($urandom_range(0, 65535));
            if (v == exp_val) v = v ^ 1;
            convert(v);
            if (i % 3 == 0) scan_frame();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/freq_display.md
Name: freq_display

Overview:
- Downstream consumer of the 1-second frequency counter output: takes the 16-bit binary frequency word and shows it on the board's 4-digit multiplexed 7-segment display.
- A sequential double-dabble converter turns binary into BCD whenever the input word changes.
- A refresh scanner drives anodes and segments at 100 MHz system clock.
- Values above 9999 raise an overflow flag and display dashes.

Parameters:
- REFRESH_DIV, 100000, CLK cycles per digit slot (1 kHz digit rate, 250 Hz frame at 100 MHz); legal range >= 2.
- BLANK_LEADING, 1, 1 = blank leading zeros; 0 = show all four digits.

Ports:
- CLK  input  1  100 MHz system clock, all logic on rising edge
- RST_N  input  1  synchronous active-low reset
- FREQ  input  16  binary frequency from the counter; may change at any cycle
- BCD  output  16  four BCD digits {thousands,hundreds,tens,ones} of last converted value
- OVF  output  1  high when last converted value > 9999
- BUSY  output  1  high while a conversion is in progress
- AN  output  4  digit anodes, active low; AN[0] = rightmost (ones)
- SEG  output  7  segments {g,f,e,d,c,b,a}, active low
- DP  output  1  decimal point, active low; held 1 (off)

Behaviour:
- Reset (RST_N low at a rising edge): state IDLE, last_freq=0, BCD=0, OVF=0, BUSY=0, refresh counter=0, digit index=0, AN=4'b1111, SEG=7'b1111111, DP=1. Reset mid-conversion aborts it; no partial result reaches BCD.
- FSM states:
  - IDLE: at an edge where FREQ != last_freq, capture shift register = FREQ, last_freq = FREQ, clear 20-bit BCD accumulator and shift count, go to SHIFT, BUSY = 1.
  - SHIFT: each edge, add 3 to every accumulator nibble >= 5, then shift {acc,shreg} left one bit (single cycle). After the 16th shift, go to DONE.
  - DONE: BCD <= acc[15:0]; OVF <= (acc[19:16] != 0); go to IDLE, BUSY <= 0.
- Latency: the capture edge is edge 0. Shifts occur on edges 1..16. BCD/OVF update on edge 17. BUSY is high from after edge 0 until after edge 17.
- FREQ changes during SHIFT/DONE are ignored. The next IDLE cycle compares against last_freq, so the latest value is always converted eventually. Intermediate values may be skipped.
- Boundary values:
  - FREQ = 0 after reset: no conversion starts (equals last_freq).
  - 9999 gives BCD=16'h9999, OVF=0.
  - 10000 gives OVF=1; BCD holds acc[15:0] (16'h0000).
  - 65535 gives OVF=1, BCD=16'h5535.
- Scanner: the refresh counter counts 0..REFRESH_DIV-1. At wrap, the digit index increments mod 4 (0→1→2→3→0).
- AN/SEG are registered every edge from the current digit index and the current BCD/OVF. AN = one-hot-low of index (index 0 → 4'b1110).
- Segment codes:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
  - Blank=1111111, dash=0111111.
  - Non-decimal nibbles cannot occur.
- Priority: OVF=1 shows dashes on all digits, with no blanking. Otherwise, with BLANK_LEADING=1, digit i (i>=1) is blank when it and all higher digits are 0. Digit 0 is never blank.
- Scanner runs independently of the converter and keeps running while BUSY, showing the previous value until DONE.

Test Plan:
- Reset with REFRESH_DIV=4, FREQ=0 → after first edge AN=1110, SEG=1000000; AN steps 1110→1101→1011→0111 every 4 cycles; digits 1–3 SEG=1111111; BUSY stays 0.
- FREQ=1234 held → BUSY rises after edge 0, BCD=16'h1234 and OVF=0 after edge 17; scan shows 4,3,2,1 (SEG 0011001, 0110000, 0100100, 1111001).
- FREQ=9999 then 10000 → first gives BCD=16'h9999, OVF=0; second gives OVF=1 and all four digits SEG=0111111; FREQ=65535 → BCD=16'h5535, OVF=1.
- FREQ=7 with BLANK_LEADING=1 → digits 3..1 blank, digit 0 SEG=1111000. Repeat with BLANK_LEADING=0 → digits 3..1 SEG=1000000.
- FREQ=100, then FREQ=250 at edge 5 of that conversion → BCD=16'h0100 at edge 17; a new conversion starts at edge 18; BCD=16'h0250 at edge 35.
- RST_N low at edge 8 of a conversion of 4321 → BCD=0, BUSY=0, AN=1111 after that edge. After release with FREQ still 4321, conversion restarts; BCD=16'h4321 is reached 18 edges later.
